// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit: op codes, FSM states,
// default latencies and the divide-by-zero quotient value.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } mdu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: {HI,LO} for mult/div, plus the accumulate
// forms when MDU_MADD_EN is defined.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [63:0] acc,
  output logic [63:0] result
);

  logic signed [63:0] rs_s64;
  logic signed [63:0] rt_s64;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;

  // Sign-magnitude divide: quotient truncates toward zero, remainder follows
  // the dividend; 8000_0000 / FFFF_FFFF falls out as 8000_0000 rem 0.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a, mag_b, q, r;
    mag_a = a[31] ? (~a + 32'd1) : a;
    mag_b = b[31] ? (~b + 32'd1) : b;
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  assign rs_s64  = {{32{rs[31]}}, rs};
  assign rt_s64  = {{32{rt[31]}}, rt};
  assign prod_s  = rs_s64 * rt_s64;
  assign prod_u  = {32'd0, rs} * {32'd0, rt};
  assign divisor = (rt == 32'd0) ? 32'd1 : rt;

`ifdef MDU_MADD_EN
  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = (rt == 32'd0) ? {rs, MDU_DIV0_LO} : div_signed(rs, divisor);
      OP_DIVU:  result = (rt == 32'd0) ? {rs, MDU_DIV0_LO} : div_unsigned(rs, divisor);
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
      default:  result = 64'd0;
    endcase
  end
`else
  logic acc_unused;
  assign acc_unused = ^acc;

  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = (rt == 32'd0) ? {rs, MDU_DIV0_LO} : div_signed(rs, divisor);
      OP_DIVU:  result = (rt == 32'd0) ? {rs, MDU_DIV0_LO} : div_unsigned(rs, divisor);
      default:  result = 64'd0;
    endcase
  end
`endif

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle MDU holding HI/LO behind a busy/done handshake.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled with macro MDU_MADD_EN.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_op_t    op_e;
  mdu_state_t state;
  logic [4:0]  cnt;
  logic [63:0] pend;
  logic [63:0] calc_result;
  logic        is_mult;
  logic        is_div;
  logic        accept;

  assign op_e = mdu_op_t'(op);

  always_comb begin
    is_mult = 1'b0;
    is_div  = 1'b0;
    case (op_e)
      OP_MULT, OP_MULTU:                     is_mult = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:  is_mult = 1'b1;
`endif
      OP_DIV, OP_DIVU:                       is_div  = 1'b1;
      default: ;
    endcase
  end

  assign accept = start && (state == ST_IDLE) && (is_mult || is_div);

  mdu_calc u_calc (
    .op     (op_e),
    .rs     (rs),
    .rt     (rt),
    .acc    ({hi, lo}),
    .result (calc_result)
  );

  // Accept stage: operands resolved into the pending result, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) pend <= calc_result;
  end

  // Control stage: FSM, latency counter, HI/LO commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            cnt   <= is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
          end else if (start && op_e == OP_MTHI) begin
            hi <= rs;
          end else if (start && op_e == OP_MTLO) begin
            lo <= rs;
          end
        end
        ST_RUN: begin
          if (cnt == 5'd1) begin
            {hi, lo} <= pend;
            busy     <= 1'b0;
            done     <= 1'b1;
            cnt      <= 5'd0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed corner cases plus randomized
// mult/div traffic against a longint arithmetic reference model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a) & 64'h0000_0000_FFFF_FFFF;
    ub = longint'(b) & 64'h0000_0000_FFFF_FFFF;
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
      OP_MADD:  return acc + 64'(sa * sb);
      OP_MADDU: return acc + ua * ub;
      OP_MSUB:  return acc - 64'(sa * sb);
      OP_MSUBU: return acc - ua * ub;
      default:  return acc;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one long op (caller is #1 after a rising edge), check latency, hold, result.
  task automatic run_long(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string name);
    logic [63:0] exp;
    int lat, n;
    exp = ref_result(o, a, b, {m_hi, m_lo});
    lat = (o == OP_DIV || o == OP_DIVU) ? DC : MC;
    op = o; rs = a; rt = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      checks++;
      if ({hi, lo} !== {m_hi, m_lo} || done !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: hi/lo=%h done=%b required %h done=0", name, {hi, lo}, done, {m_hi, m_lo});
      end
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != lat) begin
      errors++;
      $display("FAIL %s latency: busy cycles %0d required %0d", name, n, lat);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got %b required 1", name, done);
    end
    checks++;
    if ({hi, lo} !== exp) begin
      errors++;
      $display("FAIL %s result: hi/lo=%h required %h (a=%h b=%h)", name, {hi, lo}, exp, a, b);
    end
    {m_hi, m_lo} = exp;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b required 0", name, done);
    end
  endtask

  task automatic issue_short(input logic [3:0] o, input logic [31:0] a);
    op = o; rs = a; rt = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_long(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL mult_neg_const: hi=%h lo=%h required ffffffff fffffff1", hi, lo);
    end
    run_long(OP_MULTU, 32'hFFFF_FFFD, 32'd5, "multu");
    checks++;
    if (hi !== 32'h0000_0004 || lo !== 32'hFFFF_FFF1) begin
      errors++; $display("FAIL multu_const: hi=%h lo=%h required 00000004 fffffff1", hi, lo);
    end
    run_long(OP_MULT, 32'h8000_0000, 32'h8000_0000, "mult_min");
    checks++;
    if (hi !== 32'h4000_0000 || lo !== 32'd0) begin
      errors++; $display("FAIL mult_min_const: hi=%h lo=%h required 40000000 00000000", hi, lo);
    end
    run_long(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_neg_const: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
    end
    run_long(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    checks++;
    if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
      errors++; $display("FAIL div_ovf_const: hi=%h lo=%h required 00000000 80000000", hi, lo);
    end
    run_long(OP_DIVU, 32'hDEAD_BEEF, 32'd0, "divu_zero");
    checks++;
    if (hi !== 32'hDEAD_BEEF || lo !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divu_zero_const: hi=%h lo=%h required deadbeef ffffffff", hi, lo);
    end
    run_long(OP_DIV, 32'h0000_0007, 32'd0, "div_zero");
  endtask

  task automatic test_mt_while_busy();
    logic [63:0] exp;
    int n;
    exp = ref_result(OP_DIV, 32'd100, 32'd7, {m_hi, m_lo});
    op = OP_DIV; rs = 32'd100; rt = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    op = OP_MTLO; rs = 32'h1234_5678;
    @(posedge clk); #1;
    op = OP_MTHI;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (done !== 1'b1 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL mt_while_busy: done=%b hi/lo=%h required done=1 %h", done, {hi, lo}, exp);
    end
    {m_hi, m_lo} = exp;
    // Same cycle as done: MTLO must be accepted.
    issue_short(OP_MTLO, 32'h1234_5678);
    m_lo = 32'h1234_5678;
    checks++;
    if (lo !== 32'h1234_5678 || hi !== m_hi || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_after_done: lo=%h hi=%h busy=%b done=%b required lo=12345678 hi=%h", lo, hi, busy, done, m_hi);
    end
    issue_short(OP_MTHI, 32'hCAFE_F00D);
    m_hi = 32'hCAFE_F00D;
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== m_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b required hi=cafef00d lo=%h", hi, lo, busy, m_lo);
    end
  endtask

  task automatic test_undefined_op();
    issue_short(4'hF, 32'h5555_AAAA);
    checks++;
    if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL undef_op: busy=%b hi=%h lo=%h required 0 %h %h", busy, hi, lo, m_hi, m_lo);
    end
`ifdef MDU_MADD_EN
    run_long(OP_MADD, 32'hFFFF_FFFE, 32'd3, "madd");
    run_long(OP_MADDU, 32'hFFFF_FFFE, 32'd3, "maddu");
    run_long(OP_MSUB, 32'h8000_0000, 32'd2, "msub");
    run_long(OP_MSUBU, $urandom, $urandom, "msubu");
`else
    op = OP_MADD; rs = 32'd3; rt = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL madd_disabled: busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", busy, done, hi, lo, m_hi, m_lo);
    end
`endif
  endtask

  task automatic test_random();
    logic [3:0] o;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: o = OP_MULT;
        1: o = OP_MULTU;
        2: o = OP_DIV;
        default: o = OP_DIVU;
      endcase
      run_long(o, rand_word(), rand_word(), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int n;
    run_long(OP_MULT, 32'd1234, 32'hFFFF_0000, "b2b_first");
    // run_long leaves us one cycle after done; issue next op, then chain in its done cycle.
    op = OP_MULTU; rs = 32'h0001_0001; rt = 32'h0001_0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 64) begin n++; @(posedge clk); #1; end
    {m_hi, m_lo} = ref_result(OP_MULTU, 32'h0001_0001, 32'h0001_0001, {m_hi, m_lo});
    exp = ref_result(OP_DIVU, 32'd1000, 32'd7, {m_hi, m_lo});
    op = OP_DIVU; rs = 32'd1000; rt = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || {hi, lo} !== {m_hi, m_lo}) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b hi/lo=%h required busy=1 %h", busy, {hi, lo}, {m_hi, m_lo});
    end
    n = 0;
    while (busy === 1'b1 && n < 64) begin n++; @(posedge clk); #1; end
    checks++;
    if (n != DC || done !== 1'b1 || {hi, lo} !== exp) begin
      errors++;
      $display("FAIL b2b_result: cycles=%0d done=%b hi/lo=%h required %0d 1 %h", n, done, {hi, lo}, DC, exp);
    end
    {m_hi, m_lo} = exp;
  endtask

  task automatic test_reset_mid_op();
    int seen;
    op = OP_DIV; rs = 32'd99; rt = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < DC + 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_no_done: activity cycles=%0d hi=%h lo=%h required 0 0 0", seen, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_while_busy();
    test_undefined_op();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    run_long(OP_MULT, 32'd6, 32'd7, "after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
